bit_serializer: RTL and testbench

Parallel-to-serial front end for the serial pattern detector.
- Accepts WIDTH-bit words over a valid/ready handshake and buffers them in a small FIFO.
- Shifts each word out one bit per clock, least-significant bit first, so the rightmost bit reaches the detector first.
- Drives the detector's serial data input directly; idle cycles carry a fixed fill bit.

---
 rtl/bit_serializer_if.sv | 22 ++
 rtl/bit_serializer.sv | 116 +++++++++++
 tb/tb_bit_serializer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/bit_serializer_if.sv
// bit_serializer_if: word-input handshake plus serial output towards the detector.
// The master side drives words; the slave side is the serializer.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, ser_out, ser_valid, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, ser_out, ser_valid, busy
  );
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer: FIFO-buffered parallel-to-serial front end, LSB first, no idle gap between queued words.
// Defining SER_PARITY_EN appends an even-parity bit after each word.
module bit_serializer #(
  parameter int   WIDTH      = 8,
  parameter int   FIFO_DEPTH = 4,
  parameter logic IDLE_BIT   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  bit_serializer_if.slave  bus
);
  // state   | meaning
  // S_IDLE  | shifter empty; ser_out = IDLE_BIT, ser_valid = 0
  // S_SHIFT | word loaded; ser_out carries bit r_bit_cnt of the word

`ifdef SER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(NBITS);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_ser_out;
  logic             r_ser_valid;
`ifdef SER_PARITY_EN
  logic             r_parity;
`endif

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_last;
  logic [WIDTH-1:0] w_head;

  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rd_ptr];
  assign w_last  = (r_bit_cnt == CW'(NBITS - 1));
  assign w_push  = bus.din_valid && bus.din_ready;
  // A new word is taken either from idle or on the edge after the last bit, giving gapless output.
  assign w_pop   = !w_empty && ((r_state == S_IDLE) || w_last);

  assign bus.din_ready = !w_full && !reset;
  assign bus.ser_out   = r_ser_out;
  assign bus.ser_valid = r_ser_valid;
  assign bus.busy      = !w_empty || (r_state == S_SHIFT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_ser_out   <= IDLE_BIT;
      r_ser_valid <= 1'b0;
`ifdef SER_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else if (w_pop) begin
      r_state     <= S_SHIFT;
      r_shift     <= w_head >> 1;
      r_bit_cnt   <= '0;
      r_ser_out   <= w_head[0];
      r_ser_valid <= 1'b1;
`ifdef SER_PARITY_EN
      r_parity    <= ^w_head;
`endif
    end else if (r_state == S_SHIFT) begin
      if (w_last) begin
        r_state     <= S_IDLE;
        r_bit_cnt   <= '0;
        r_ser_out   <= IDLE_BIT;
        r_ser_valid <= 1'b0;
      end else begin
        r_bit_cnt <= r_bit_cnt + CW'(1);
        r_shift   <= r_shift >> 1;
`ifdef SER_PARITY_EN
        r_ser_out <= (r_bit_cnt == CW'(WIDTH - 1)) ? r_parity : r_shift[0];
`else
        r_ser_out <= r_shift[0];
`endif
      end
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed self-checking bench; every accepted word queues its
// expected bit stream, and each ser_valid cycle pops and compares one bit.
module tb_bit_serializer;
  localparam int WIDTH      = 8;
  localparam int FIFO_DEPTH = 4;
`ifdef SER_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(WIDTH)) bus ();

  bit_serializer #(
    .WIDTH(WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .IDLE_BIT(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_valid = 0;
  int   cyc_no = 0;

  // Reference 0010 detector sampling ser_out on the falling edge.
  logic [3:0] det_sr = 4'b1111;
  int         det_matches = 0;
  always @(negedge clk) begin
    det_sr <= {det_sr[2:0], bus.ser_out};
    if ({det_sr[2:0], bus.ser_out} == 4'b0010) det_matches <= det_matches + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) exp_q.push_back(w[i]);
`ifdef SER_PARITY_EN
    exp_q.push_back(^w);
`endif
  endtask

  task automatic cyc(output logic acc);
    logic [WIDTH-1:0] w;
    logic             e;
    @(negedge clk);
    acc = bus.din_valid && bus.din_ready;
    w   = bus.din;
    @(posedge clk);
    #1;
    cyc_no++;
    if (reset) exp_q.delete();
    else if (acc) push_word(w);
    if (bus.ser_valid) begin
      n_valid++;
      if (exp_q.size() == 0) check("sb_underflow", bus.ser_valid, 1'b0);
      else begin
        e = exp_q.pop_front();
        check("ser_bit", bus.ser_out, e);
      end
    end
  endtask

  task automatic drain(input string tag);
    logic d;
    int   t;
    t = 0;
    while ((bus.busy || bus.ser_valid) && t < 200) begin
      cyc(d);
      t++;
    end
    check({tag, "_idle"}, {bus.busy, bus.ser_valid}, 2'b00);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic send(input logic [WIDTH-1:0] w, output logic acc);
    bus.din       = w;
    bus.din_valid = 1'b1;
    cyc(acc);
    bus.din_valid = 1'b0;
  endtask

  initial begin
    logic             acc;
    logic [WIDTH-1:0] words [6];
    int               acc_cyc [6];
    int               v0, run, t, m0;

    bus.din       = '0;
    bus.din_valid = 1'b0;

    // Reset behaviour, with a write offered during reset that must be dropped
    bus.din       = 8'h5A;
    bus.din_valid = 1'b1;
    repeat (3) cyc(acc);
    check("rst_ser_out", bus.ser_out, 1'b1);
    check("rst_ser_valid", bus.ser_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_din_ready", bus.din_ready, 1'b0);
    bus.din_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("post_rst_din_ready", bus.din_ready, 1'b1);
    cyc(acc);
    check("rst_write_dropped", bus.busy, 1'b0);

    // Single word 8'h12: latency and exact valid window
    v0 = n_valid;
    send(8'h12, acc);
    check("t1_accept", acc, 1'b1);
    check("t1_latency_valid", bus.ser_valid, 1'b0);
    check("t1_busy", bus.busy, 1'b1);
    cyc(acc);
    check("t1_bit0_valid", bus.ser_valid, 1'b1);
    check("t1_bit0", bus.ser_out, 1'b0);
    for (int k = 1; k < NB; k++) begin
      cyc(acc);
      check("t1_valid_hold", bus.ser_valid, 1'b1);
    end
    cyc(acc);
    check("t1_end_ser_out", bus.ser_out, 1'b1);
    check("t1_end_ser_valid", bus.ser_valid, 1'b0);
    check("t1_end_busy", bus.busy, 1'b0);
    check("t1_valid_count", n_valid - v0, NB);
    check("t1_sb_empty", exp_q.size(), 0);

    // Back-to-back 8'hA5, 8'h0F: one contiguous valid run
    send(8'hA5, acc);
    check("t2_accept0", acc, 1'b1);
    send(8'h0F, acc);
    check("t2_accept1", acc, 1'b1);
    t = 0;
    while (!bus.ser_valid && t < 10) begin
      cyc(acc);
      t++;
    end
    run = 0;
    while (bus.ser_valid && run < 100) begin
      run++;
      cyc(acc);
    end
    check("t2_contiguous_run", run, 2 * NB);
    drain("t2");

    // Six words with din_valid held: fill, backpressure, ordering
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int i = 0; i < 6; i++) begin
      bus.din       = words[i];
      bus.din_valid = 1'b1;
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 40) begin
        cyc(acc);
        t++;
      end
      check("t3_accept_in_time", acc, 1'b1);
      acc_cyc[i] = cyc_no;
      if (i == 4) check("t3_full_din_ready", bus.din_ready, 1'b0);
    end
    bus.din_valid = 1'b0;
    check("t3_fill_back_to_back", acc_cyc[4] - acc_cyc[0], 4);
    check("t3_w5_after_w1_pop", acc_cyc[5] - acc_cyc[4], NB - 2);
    drain("t3");

    // Reset mid-word with two words queued
    v0 = n_valid;
    send(8'hFF, acc);
    send(8'h3C, acc);
    send(8'hC3, acc);
    cyc(acc);
    check("t4_bits_before_reset", n_valid - v0, 3);
    reset = 1'b1;
    cyc(acc);
    check("t4_rst_ser_out", bus.ser_out, 1'b1);
    check("t4_rst_ser_valid", bus.ser_valid, 1'b0);
    check("t4_rst_busy", bus.busy, 1'b0);
    reset = 1'b0;
    repeat (3 * NB) cyc(acc);
    check("t4_no_queued_output", n_valid - v0, 3);
    check("t4_idle_busy", bus.busy, 1'b0);

    // Chained detector sees 0010 exactly once for 8'b0000_1000
    m0 = det_matches;
    send(8'h08, acc);
    drain("t5");
    repeat (4) cyc(acc);
    check("t5_detector_matches", det_matches - m0, 1);

`ifdef SER_PARITY_EN
    // Parity trailer: 8'h07 -> 1, 8'h03 -> 0 (checked through the scoreboard)
    v0 = n_valid;
    send(8'h07, acc);
    drain("t6a");
    send(8'h03, acc);
    drain("t6b");
    check("t6_valid_count", n_valid - v0, 2 * NB);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
